// File: rtl/store_narrow_rmw.sv
// rtl/store_narrow_rmw.sv - store-path narrowing unit with sub-word read-modify-write
// Optional STORE_BYTE_STROBE_EN: byte-enable writes with replicated lanes instead of RMW.
module store_narrow_rmw #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  input  logic [1:0]    req_size,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wr,
`ifdef STORE_BYTE_STROBE_EN
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be
`else
  output logic [DW-1:0] mem_wdata
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERR   = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t state;
  logic   misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

`ifdef STORE_BYTE_STROBE_EN
  logic [DW-1:0] wdata_rep;
  logic [3:0]    be_acc;

  assign mem_rd = 1'b0;

  always_comb begin
    wdata_rep = req_data;
    be_acc    = 4'b1111;
    case (req_size)
      2'b00: begin
        wdata_rep = {4{req_data[7:0]}};
        be_acc    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        wdata_rep = {2{req_data[15:0]}};
        be_acc    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_rep = req_data;
        be_acc    = 4'b1111;
      end
    endcase
  end
`else
  logic [1:0]    lane_q;
  logic          half_q;
  logic [15:0]   data_q;
  logic [DW-1:0] merged;

  // Only the addressed lane is replaced; the rest is the word just read back.
  always_comb begin
    merged = mem_rdata;
    if (half_q) begin
      if (lane_q[1]) merged[31:16] = data_q;
      else           merged[15:0]  = data_q;
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef STORE_BYTE_STROBE_EN
      mem_be    <= 4'b0000;
`else
      mem_rd    <= 1'b0;
      lane_q    <= 2'b00;
      half_q    <= 1'b0;
      data_q    <= 16'h0000;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            mem_addr  <= {req_addr[AW-1:2], 2'b00};
            if (misaligned) begin
              state <= S_ERR;
              err   <= 1'b1;
            end
`ifdef STORE_BYTE_STROBE_EN
            else begin
              state     <= S_WRITE;
              mem_wr    <= 1'b1;
              done      <= 1'b1;
              mem_wdata <= wdata_rep;
              mem_be    <= be_acc;
            end
`else
            else if (req_size == 2'b10) begin
              state     <= S_WRITE;
              mem_wr    <= 1'b1;
              done      <= 1'b1;
              mem_wdata <= req_data;
            end else begin
              state  <= S_READ;
              mem_rd <= 1'b1;
              lane_q <= req_addr[1:0];
              half_q <= req_size[0];
              data_q <= req_data[15:0];
            end
`endif
          end
        end
        S_ERR: begin
          err       <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
`ifndef STORE_BYTE_STROBE_EN
        S_READ: begin
          mem_rd <= 1'b0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            mem_wdata <= merged;
            mem_wr    <= 1'b1;
            done      <= 1'b1;
            state     <= S_WRITE;
          end
        end
`endif
        S_WRITE: begin
          mem_wr    <= 1'b0;
          done      <= 1'b0;
          req_ready <= 1'b1;
`ifdef STORE_BYTE_STROBE_EN
          mem_be    <= 4'b0000;
`endif
          state     <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// tb/tb_store_narrow_rmw.sv - directed and random stores against a lane-arithmetic reference model
// Follows STORE_BYTE_STROBE_EN when defined.
module tb_store_narrow_rmw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_wr;
  logic [31:0] mem_wdata;
`ifdef STORE_BYTE_STROBE_EN
  logic [3:0]  mem_be;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_narrow_rmw #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr),
`ifdef STORE_BYTE_STROBE_EN
    .mem_wdata(mem_wdata), .mem_be(mem_be)
`else
    .mem_wdata(mem_wdata)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] addr, input logic [1:0] size);
    return (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] addr, input logic [31:0] data,
                                              input logic [1:0] size, input logic [31:0] rdata);
    int unsigned sh;
    logic [31:0] mask;
    if (size == 2'd2) return data;
`ifdef STORE_BYTE_STROBE_EN
    if (size == 2'd0) return (data & 32'hFF) * 32'h0101_0101;
    return (data & 32'hFFFF) * 32'h0001_0001;
`else
    sh   = (size == 2'd0) ? 8 * (addr % 4) : 16 * ((addr / 2) % 2);
    mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (rdata & ~mask) | ((data << sh) & mask);
`endif
  endfunction

  task automatic do_store(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input int lat, input logic [31:0] rdata);
    bit mis;
    bit rmw;
    int rd_c = 0, wr_c = 0, err_c = 0, rdy_c = 0;
    int rd_n = 0, wr_n = 0, err_n = 0, done_n = 0;
    int multi = 0, addr_bad = 0, rv_at = -1;
    logic [31:0] wd = '0;
    logic [3:0]  be = '0;
    mis = model_err(addr, size);
`ifdef STORE_BYTE_STROBE_EN
    rmw = 1'b0;
`else
    rmw = !mis && size != 2'd2;
`endif
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_data = data; req_size = size;
    @(posedge clk);
    for (int c = 1; c <= lat + 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0; req_data = $urandom; req_addr = $urandom;
      end
      if (mem_addr !== {addr[31:2], 2'b00}) addr_bad++;
      if ((int'(mem_rd) + int'(mem_wr) + int'(err)) > 1 || done !== mem_wr) multi++;
      if (mem_rd) begin rd_n++; if (rd_c == 0) rd_c = c; rv_at = c + lat; end
      if (mem_wr) begin
        wr_n++; if (wr_c == 0) wr_c = c; wd = mem_wdata;
`ifdef STORE_BYTE_STROBE_EN
        be = mem_be;
`endif
      end
      if (done) done_n++;
      if (err) begin err_n++; if (err_c == 0) err_c = c; end
      mem_rvalid = (c == rv_at);
      mem_rdata  = (c == rv_at) ? rdata : $urandom;
      if (req_ready && c >= 2) begin rdy_c = c; break; end
    end
    mem_rvalid = 1'b0;
    chk({name, ".ready_cycle"}, rdy_c, rmw ? 3 + lat : 2);
    chk({name, ".err_count"}, err_n, mis ? 1 : 0);
    chk({name, ".done_count"}, done_n, mis ? 0 : 1);
    chk({name, ".wr_count"}, wr_n, mis ? 0 : 1);
    chk({name, ".rd_count"}, rd_n, rmw ? 1 : 0);
    chk({name, ".addr_stable"}, addr_bad, 0);
    chk({name, ".strobe_overlap"}, multi, 0);
    if (mis) chk({name, ".err_cycle"}, err_c, 1);
    if (rmw) chk({name, ".rd_cycle"}, rd_c, 1);
    if (!mis) begin
      chk({name, ".wr_cycle"}, wr_c, rmw ? 2 + lat : 1);
      chk({name, ".wdata"}, wd, model_wdata(addr, data, size, rdata));
`ifdef STORE_BYTE_STROBE_EN
      chk({name, ".be"}, be, 32'((size == 2'd0 ? 1 : size == 2'd1 ? 3 : 15) << (addr % 4)));
`endif
    end
  endtask

  initial begin
    int wr_seen;
    repeat (3) @(negedge clk);
    chk("reset.req_ready", req_ready, 1);
    chk("reset.mem_wr", mem_wr, 0);
    chk("reset.mem_rd", mem_rd, 0);
    chk("reset.done_err", {done, err}, 0);
    chk("reset.mem_addr", mem_addr, 0);
    chk("reset.mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release.req_ready", req_ready, 1);

    do_store("word_100", 32'h100, 32'hDEADBEEF, 2'd2, 1, 32'h0);
    do_store("byte_203", 32'h203, 32'h12345678, 2'd0, 3, 32'hAABBCCDD);
    do_store("half_302", 32'h302, 32'h0000CAFE, 2'd1, 1, 32'h11223344);
    do_store("half_301", 32'h301, 32'h0000CAFE, 2'd1, 1, 32'h11223344);
    do_store("size11_0", 32'h0, 32'h55AA55AA, 2'd3, 1, 32'h0);
    do_store("word_6", 32'h6, 32'h01020304, 2'd2, 1, 32'h0);
    do_store("byte_1", 32'h1, 32'h000000AB, 2'd0, 2, 32'h99887766);
    do_store("half_0", 32'h40, 32'h7777BEEF, 2'd1, 4, 32'hFFFFFFFF);

`ifndef STORE_BYTE_STROBE_EN
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h400; req_data = 32'h5A; req_size = 2'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort.rd", mem_rd, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.strobes", {mem_rd, mem_wr, done, err}, 0);
    chk("abort.mem_addr", mem_addr, 0);
    chk("abort.mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    wr_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (mem_wr || mem_rd || done) wr_seen++;
      @(negedge clk);
    end
    chk("abort.no_write", wr_seen, 0);
    chk("abort.req_ready", req_ready, 1);
`endif
    do_store("post_abort_word", 32'h500, 32'h0BADF00D, 2'd2, 1, 32'h0);

    for (int i = 0; i < 24; i++) begin
      do_store($sformatf("rand%0d", i), $urandom, $urandom, 2'($urandom_range(0, 3)),
               int'($urandom_range(1, 4)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_narrow_rmw.md
# store_narrow_rmw

Store-path narrowing unit for the MIPS core, the counterpart of the load-side sign extension. It takes a register value plus a size code (byte, half, word) and a byte address from the execute stage, and places the low-order byte or halfword into the correct lane of a 32-bit memory word. Sub-word stores use a read-modify-write sequence over a simple single-outstanding memory port; word stores are written directly. The block sits between the execute-stage store request and the data memory.

## Interface
- `AW`, default 32: address width; byte address.
- `DW`, default 32: data width. Fixed at 32; other values are unsupported.

Ports:
- `clk`  in  1  Rising-edge clock.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `req_valid`  in  1  Store request present.
- `req_ready`  out  1  Block can accept a request. High only in IDLE.
- `req_addr`  in  AW  Byte address.
- `req_data`  in  32  Register value; only the low byte or halfword is used for sub-word stores.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- `done`  out  1  One-cycle pulse; the store has completed.
- `err`  out  1  One-cycle pulse; the request was misaligned or reserved, and no memory access occurred.
- `mem_addr`  out  AW  Word-aligned address `{req_addr[AW-1:2],2'b00}`; held for the whole operation.
- `mem_rd`  out  1  One-cycle read strobe.
- `mem_rvalid`  in  1  Read data valid; any latency of 1 cycle or more.
- `mem_rdata`  in  32  Read data.
- `mem_wr`  out  1  One-cycle write strobe.
- `mem_wdata`  out  32  Write data.

## Operation
- **Accept.** A request is accepted when `req_valid && req_ready` at a rising edge. At that edge the block captures `addr`, `data` and `size`, and the FSM leaves IDLE.
- **Error check.** A request is misaligned when any of these holds:
  - half with `addr[0]=1`
  - word with `addr[1:0]!=0`
  - size = 11
- **States.**
  - IDLE: `req_ready=1`. On accept, go to ERR if misaligned, WRITE if word, otherwise READ.
  - ERR: `err=1`, then IDLE.
  - READ: `mem_rd=1`, then WAIT.
  - WAIT: stay until `mem_rvalid=1`. On that edge, capture the merged word, then go to WRITE.
  - WRITE: `mem_wr=1` and `done=1` in the same cycle, then IDLE.
- **Lane placement (little-endian).**
  - Byte to lane k=`addr[1:0]`: bits [8k+7:8k] = `data[7:0]`; all other bits come from `mem_rdata`.
  - Half: `addr[1]=0` → [15:0], `addr[1]=1` → [31:16]; all other bits come from `mem_rdata`.
  - Word: `mem_wdata = data`.
- **Ignored inputs.**
  - `mem_rvalid` is ignored outside WAIT.
  - `req_valid` is ignored outside IDLE; there is no queueing.
- **Strobes.** At most one of `mem_rd`, `mem_wr`, `done`, `err` is high in any cycle, except that `done` and `mem_wr` coincide.
- **Reset.** `rst_n` low at any time forces IDLE immediately, even mid-operation.
  - All strobes go to 0.
  - `mem_addr` and `mem_wdata` go to 0.
  - `req_ready` goes to 1 after reset release.
  - No write is issued for an aborted request.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Word store: accept at edge 0; `mem_wr`/`done` high during cycle 1; `req_ready` back high in cycle 2.
- Sub-word store with a memory read latency of L (L ≥ 1; `mem_rvalid` arrives L cycles after `mem_rd`):
  - `mem_rd` is high in cycle 1.
  - `mem_rvalid` arrives in cycle 1+L.
  - `mem_wr` is high in cycle 2+L.
  - Minimum total is 4 cycles from accept to `req_ready`.
- Error: `err` is high in cycle 1; `req_ready` is high again in cycle 2.
- `mem_addr` is stable from cycle 1 until the cycle after WRITE/ERR.

## Configuration
- `STORE_BYTE_STROBE_EN` defined:
  - Adds output `mem_be` [3:0], byte enables for the active lanes: byte = one-hot at k; half = 0011 or 1100; word = 1111.
  - READ and WAIT are never entered; every aligned store goes IDLE → WRITE with `mem_wdata` lanes replicated (`{4{byte}}` or `{2{half}}`).
  - `mem_rd` is tied to 0.
  - `mem_be` resets to 0 and is 0 outside WRITE.
- Undefined: no `mem_be` port; read-modify-write as described above.

## Test plan
- Word store, addr 0x100, data 0xDEADBEEF → `mem_wr` in cycle 1, `mem_addr=0x100`, `mem_wdata=0xDEADBEEF`, `done=1`, and `mem_rd` never asserted.
- Byte store, addr 0x203, data 0x12345678, `mem_rdata=0xAABBCCDD`, L=3 → `mem_rd` in cycle 1, `mem_wr` in cycle 5, `mem_wdata=0x78BBCCDD`, `mem_addr=0x200`.
- Half store, addr 0x302, data 0x0000CAFE, `mem_rdata=0x11223344`, L=1 → `mem_wdata=0xCAFE3344`; repeat at addr 0x301 → `err` in cycle 1, no `mem_rd`/`mem_wr`.
- Size 11 at addr 0x0, and word at addr 0x6 → `err` pulse for each, `done` stays 0, `req_ready` high again 2 cycles after accept.
- `rst_n` low during WAIT; `mem_rvalid` arrives after release → no `mem_wr`, `req_ready=1`, and the next word request completes normally.
- With `STORE_BYTE_STROBE_EN`: byte at addr 0x1, data 0xAB → `mem_wr` in cycle 1, `mem_be=0010`, `mem_wdata=0xABABABAB`.
